hazard_control_unit: RTL and testbench

Generates the per-stage `enable` and `flush` controls for the PipeRegister instances in the 5-stage pipeline: PC, IF/ID, ID/EX, EX/MEM and MEM/WB. It detects load-use hazards, taken branches/jumps and data-memory wait states. It also sequences multi-cycle stalls with a small FSM. It sits beside the decode stage and drives every pipe register's control inputs.

---
 rtl/pipeline_pkg.sv | 12 +
 rtl/load_use_detector.sv | 24 ++
 rtl/hazard_control_unit.sv | 122 ++++++++++++
 tb/tb_hazard_control_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: hazard FSM state encoding, default widths.
package pipeline_pkg;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } hcu_state_e;

  localparam int DEFAULT_REG_ADDR_W = 5;
  localparam int PERF_CNT_W         = 32;

endpackage

// File: rtl/load_use_detector.sv
// Flags when the instruction in ID reads the destination of a load still in EX.
module load_use_detector
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W = DEFAULT_REG_ADDR_W
) (
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  input  logic [REG_ADDR_W-1:0] ifid_rs_i,
  input  logic [REG_ADDR_W-1:0] ifid_rt_i,
  input  logic                  ifid_uses_rt_i,
  output logic                  load_use_o
);

  logic rs_match;
  logic rt_match;

  assign rs_match = (idex_rt_i == ifid_rs_i);
  assign rt_match = ifid_uses_rt_i && (idex_rt_i == ifid_rt_i);

  // Register zero is hardwired, so a load targeting it never creates a hazard.
  assign load_use_o = idex_mem_read_i && (idex_rt_i != '0) && (rs_match || rt_match);

endmodule

// File: rtl/hazard_control_unit.sv
// Pipe-register enable/flush generation for load-use, branch and memory-wait hazards.
// Define HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module hazard_control_unit
  import pipeline_pkg::*;
#(
  parameter int REG_ADDR_W        = DEFAULT_REG_ADDR_W,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [REG_ADDR_W-1:0] ifid_rs_i,
  input  logic [REG_ADDR_W-1:0] ifid_rt_i,
  input  logic                  ifid_uses_rt_i,
  input  logic                  idex_mem_read_i,
  input  logic [REG_ADDR_W-1:0] idex_rt_i,
  input  logic                  branch_taken_i,
  input  logic                  mem_ready_i,
  output logic                  pc_enable_o,
  output logic                  ifid_enable_o,
  output logic                  idex_enable_o,
  output logic                  exmem_enable_o,
  output logic                  memwb_enable_o,
  output logic                  ifid_flush_o,
  output logic                  idex_flush_o,
  output logic                  exmem_flush_o,
  output logic [PERF_CNT_W-1:0] stall_count_o,
  output logic [PERF_CNT_W-1:0] flush_count_o
);

  // First stall cycle happens in RUN, so the counter holds the bubbles still owed after the next one.
  localparam logic [1:0] STALL_INIT = (LOAD_STALL_CYCLES > 1) ? 2'(LOAD_STALL_CYCLES - 2) : 2'd0;

  hcu_state_e state_reg;
  logic [1:0] stall_cnt_reg;
  logic       load_use;
  logic       stall_active;

  load_use_detector #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_load_use_detector (
    .idex_mem_read_i (idex_mem_read_i),
    .idex_rt_i       (idex_rt_i),
    .ifid_rs_i       (ifid_rs_i),
    .ifid_rt_i       (ifid_rt_i),
    .ifid_uses_rt_i  (ifid_uses_rt_i),
    .load_use_o      (load_use)
  );

  assign stall_active = (state_reg == LOAD_STALL) || load_use;

  always_comb begin
    pc_enable_o    = 1'b1;
    ifid_enable_o  = 1'b1;
    idex_enable_o  = 1'b1;
    exmem_enable_o = 1'b1;
    memwb_enable_o = 1'b1;
    ifid_flush_o   = 1'b0;
    idex_flush_o   = 1'b0;
    exmem_flush_o  = 1'b0;
    if (!mem_ready_i) begin
      pc_enable_o    = 1'b0;
      ifid_enable_o  = 1'b0;
      idex_enable_o  = 1'b0;
      exmem_enable_o = 1'b0;
      memwb_enable_o = 1'b0;
    end else if (branch_taken_i) begin
      ifid_flush_o = 1'b1;
      idex_flush_o = 1'b1;
    end else if (stall_active) begin
      pc_enable_o   = 1'b0;
      ifid_enable_o = 1'b0;
      idex_flush_o  = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= RUN;
      stall_cnt_reg <= 2'd0;
    end else if (mem_ready_i) begin
      if (branch_taken_i) begin
        state_reg     <= RUN;
        stall_cnt_reg <= 2'd0;
      end else if (state_reg == LOAD_STALL) begin
        if (stall_cnt_reg == 2'd0) begin
          state_reg <= RUN;
        end else begin
          stall_cnt_reg <= stall_cnt_reg - 2'd1;
        end
      end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
        state_reg     <= LOAD_STALL;
        stall_cnt_reg <= STALL_INIT;
      end
    end
  end

`ifdef HAZARD_PERF_EN
  logic [PERF_CNT_W-1:0] stall_count_reg;
  logic [PERF_CNT_W-1:0] flush_count_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_count_reg <= '0;
      flush_count_reg <= '0;
    end else if (mem_ready_i) begin
      if (!pc_enable_o && (stall_count_reg != '1)) begin
        stall_count_reg <= stall_count_reg + 1'b1;
      end
      if (branch_taken_i && (flush_count_reg != '1)) begin
        flush_count_reg <= flush_count_reg + 1'b1;
      end
    end
  end

  assign stall_count_o = stall_count_reg;
  assign flush_count_o = flush_count_reg;
`else
  assign stall_count_o = '0;
  assign flush_count_o = '0;
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Randomized check of two hazard_control_unit builds (1 and 3 load-use bubbles) against a bubble-count model.
module tb_hazard_control_unit;

  logic       clk;
  logic       reset;
  logic [4:0] ifid_rs;
  logic [4:0] ifid_rt;
  logic       ifid_uses_rt;
  logic       idex_mem_read;
  logic [4:0] idex_rt;
  logic       branch_taken;
  logic       mem_ready;

  logic pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_fl1, idex_fl1, exmem_fl1;
  logic pc_en3, ifid_en3, idex_en3, exmem_en3, memwb_en3, ifid_fl3, idex_fl3, exmem_fl3;
  logic [31:0] stall_cnt1, flush_cnt1, stall_cnt3, flush_cnt3;

  int checks = 0;
  int errors = 0;

  // Model state: bubbles still owed after the current cycle, plus expected counter values.
  int rem1 = 0;
  int rem3 = 0;
  int exp_stall1 = 0;
  int exp_flush1 = 0;
  int exp_stall3 = 0;
  int exp_flush3 = 0;

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(1)) u_dut1 (
    .clk(clk), .reset(reset),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(ifid_uses_rt),
    .idex_mem_read_i(idex_mem_read), .idex_rt_i(idex_rt),
    .branch_taken_i(branch_taken), .mem_ready_i(mem_ready),
    .pc_enable_o(pc_en1), .ifid_enable_o(ifid_en1), .idex_enable_o(idex_en1),
    .exmem_enable_o(exmem_en1), .memwb_enable_o(memwb_en1),
    .ifid_flush_o(ifid_fl1), .idex_flush_o(idex_fl1), .exmem_flush_o(exmem_fl1),
    .stall_count_o(stall_cnt1), .flush_count_o(flush_cnt1)
  );

  hazard_control_unit #(.REG_ADDR_W(5), .LOAD_STALL_CYCLES(3)) u_dut3 (
    .clk(clk), .reset(reset),
    .ifid_rs_i(ifid_rs), .ifid_rt_i(ifid_rt), .ifid_uses_rt_i(ifid_uses_rt),
    .idex_mem_read_i(idex_mem_read), .idex_rt_i(idex_rt),
    .branch_taken_i(branch_taken), .mem_ready_i(mem_ready),
    .pc_enable_o(pc_en3), .ifid_enable_o(ifid_en3), .idex_enable_o(idex_en3),
    .exmem_enable_o(exmem_en3), .memwb_enable_o(memwb_en3),
    .ifid_flush_o(ifid_fl3), .idex_flush_o(idex_fl3), .exmem_flush_o(exmem_fl3),
    .stall_count_o(stall_cnt3), .flush_count_o(flush_cnt3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Control bits packed as {pc,ifid,idex,exmem,memwb enables, ifid,idex,exmem flushes}.
  function automatic logic [7:0] exp_ctrl(input int rem, input bit lu, input bit br, input bit rdy);
    if (!rdy) return 8'b00000_000;
    if (br) return 8'b11111_110;
    if (rem > 0 || lu) return 8'b00111_010;
    return 8'b11111_000;
  endfunction

  function automatic bit model_load_use(input bit ld, input int rtx, input int rs, input int rt, input bit uses);
    return ld && (rtx != 0) && ((rtx == rs) || (uses && rtx == rt));
  endfunction

  function automatic int next_rem(input int rem, input bit lu, input bit br, input bit rdy, input int bubbles);
    if (!rdy) return rem;
    if (br) return 0;
    if (rem > 0) return rem - 1;
    if (lu) return bubbles - 1;
    return 0;
  endfunction

  task automatic check_counters(input string tag);
`ifdef HAZARD_PERF_EN
    check_val({tag, ".stall1"}, stall_cnt1, 32'(exp_stall1));
    check_val({tag, ".flush1"}, flush_cnt1, 32'(exp_flush1));
    check_val({tag, ".stall3"}, stall_cnt3, 32'(exp_stall3));
    check_val({tag, ".flush3"}, flush_cnt3, 32'(exp_flush3));
`else
    check_val({tag, ".stall1"}, stall_cnt1, 32'd0);
    check_val({tag, ".flush1"}, flush_cnt1, 32'd0);
    check_val({tag, ".stall3"}, stall_cnt3, 32'd0);
    check_val({tag, ".flush3"}, flush_cnt3, 32'd0);
`endif
  endtask

  // Called at a falling edge: drive, check the settled Mealy outputs, advance the model at the rising edge.
  task automatic cycle(input string tag, input bit ld, input int rtx, input int rs, input int rt,
                       input bit uses, input bit br, input bit rdy);
    bit lu;
    logic [7:0] e1, e3;
    idex_mem_read = ld;
    idex_rt       = 5'(rtx);
    ifid_rs       = 5'(rs);
    ifid_rt       = 5'(rt);
    ifid_uses_rt  = uses;
    branch_taken  = br;
    mem_ready     = rdy;
    #1;
    lu = model_load_use(ld, rtx, rs, rt, uses);
    e1 = exp_ctrl(rem1, lu, br, rdy);
    e3 = exp_ctrl(rem3, lu, br, rdy);
    check_val({tag, ".ctrl1"},
              {24'd0, pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_fl1, idex_fl1, exmem_fl1},
              {24'd0, e1});
    check_val({tag, ".ctrl3"},
              {24'd0, pc_en3, ifid_en3, idex_en3, exmem_en3, memwb_en3, ifid_fl3, idex_fl3, exmem_fl3},
              {24'd0, e3});
    check_counters(tag);
    $display("cycle %-10s ld=%0b rtx=%0d rs=%0d rt=%0d uses=%0b br=%0b rdy=%0b ctrl1=%b ctrl3=%b",
             tag, ld, rtx, rs, rt, uses, br, rdy, e1, e3);
    @(posedge clk);
    if (rdy && !e1[7]) exp_stall1++;
    if (rdy && !e3[7]) exp_stall3++;
    if (rdy && br) begin
      exp_flush1++;
      exp_flush3++;
    end
    rem1 = next_rem(rem1, lu, br, rdy, 1);
    rem3 = next_rem(rem3, lu, br, rdy, 3);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) cycle(tag, 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b1);
  endtask

  // Assert reset between edges; state and counters must clear without waiting for a clock.
  task automatic reset_pulse(input string tag);
    idex_mem_read = 1'b0;
    branch_taken  = 1'b0;
    mem_ready     = 1'b1;
    reset         = 1'b0;
    #1;
    rem1 = 0;
    rem3 = 0;
    exp_stall1 = 0;
    exp_flush1 = 0;
    exp_stall3 = 0;
    exp_flush3 = 0;
    check_val({tag, ".ctrl1"},
              {24'd0, pc_en1, ifid_en1, idex_en1, exmem_en1, memwb_en1, ifid_fl1, idex_fl1, exmem_fl1},
              {24'd0, 8'b11111_000});
    check_val({tag, ".ctrl3"},
              {24'd0, pc_en3, ifid_en3, idex_en3, exmem_en3, memwb_en3, ifid_fl3, idex_fl3, exmem_fl3},
              {24'd0, 8'b11111_000});
    check_counters(tag);
    $display("reset %-10s asserted", tag);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset         = 1'b0;
    ifid_rs       = '0;
    ifid_rt       = '0;
    ifid_uses_rt  = 1'b0;
    idex_mem_read = 1'b0;
    idex_rt       = '0;
    branch_taken  = 1'b0;
    mem_ready     = 1'b1;
    #1;
    check_counters("por");
    @(negedge clk);
    reset = 1'b1;

    cycle("lu_rs8", 1'b1, 8, 8, 3, 1'b0, 1'b0, 1'b1);
    idle("after_lu", 3);
    cycle("reg_zero", 1'b1, 0, 0, 0, 1'b1, 1'b0, 1'b1);
    cycle("rt_unused", 1'b1, 9, 1, 9, 1'b0, 1'b0, 1'b1);
    cycle("rt_used", 1'b1, 9, 1, 9, 1'b1, 1'b0, 1'b1);
    idle("after_rt", 3);
    cycle("abort_lu", 1'b1, 8, 8, 0, 1'b0, 1'b0, 1'b1);
    cycle("abort_br", 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    idle("after_abt", 2);
    cycle("lu_and_br", 1'b1, 8, 8, 0, 1'b0, 1'b1, 1'b1);
    idle("after_sim", 2);
    cycle("wait_lu", 1'b1, 8, 8, 0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cycle("mem_wait", 1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    idle("resume", 3);
    cycle("rst_lu", 1'b1, 8, 8, 0, 1'b0, 1'b0, 1'b1);
    reset_pulse("rst_mid");
    idle("after_rst", 2);

    for (int h = 0; h < 5; h++) begin
      cycle("perf_lu", 1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b1);
      idle("perf_gap", 3);
    end
    for (int b = 0; b < 3; b++) cycle("perf_br", 1'b0, 0, 0, 0, 1'b0, 1'b1, 1'b1);
    idle("perf_end", 1);

    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 149) == 0) begin
        reset_pulse("rand_rst");
      end else begin
        cycle("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) != 0));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
